// File: rtl/dout_seq_ctrl_pkg.sv
// Shared constants, state encoding and entry packing for the DOUT playback sequencer.
// Table entries are kept as {dwell[15:0], mask[3:0], 4'b0, value[3:0]}.
package dout_seq_ctrl_pkg;

    localparam logic [3:0] ADDR_DSEQ     = 4'hD;
    localparam logic [3:0] ADDR_MAIN     = 4'h1;
    localparam logic [3:0] REG_DIGIOUT   = 4'h3;
    localparam logic [3:0] OFF_DSEQ_CTRL = 4'h0;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_STOP_BIT  = 1;
    localparam int CTRL_LOOP_BIT  = 2;
    localparam int CTRL_LEN_LSB   = 8;
    localparam int CTRL_LEN_W     = 4;

    localparam int ENTRY_W = 28;

    localparam logic [15:0] DOUT_SEQ_ADDR = {ADDR_MAIN, 8'h00, REG_DIGIOUT};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DWELL = 2'd2
    } seq_state_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [31:0] w);
        return {w[31:16], w[11:8], 4'b0000, w[3:0]};
    endfunction

    function automatic logic [31:0] unpack_entry(input logic [ENTRY_W-1:0] e);
        return {e[27:12], 4'b0000, e[11:0]};
    endfunction

endpackage

// File: rtl/dout_seq_ctrl_dseq_table.sv
// Sequence table register file: one host write port, a host read port and a sequencer read port.
// Entries live at indices 1..DEPTH; any other index reads as zero and ignores writes.
module dseq_table
    import dout_seq_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n_i,
    input  logic               we_i,
    input  logic [3:0]         waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [3:0]         host_raddr_i,
    output logic [ENTRY_W-1:0] host_rdata_o,
    input  logic [3:0]         seq_raddr_i,
    output logic [ENTRY_W-1:0] seq_rdata_o
);

    logic [ENTRY_W-1:0] entry_w [1:DEPTH];

    genvar gi;
    generate
        for (gi = 1; gi <= DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_q;

            always_ff @(posedge clk) begin
                if (!rst_n_i) begin
                    entry_q <= '0;
                end else if (we_i && (waddr_i == 4'(gi))) begin
                    entry_q <= wdata_i;
                end
            end

            assign entry_w[gi] = entry_q;
        end
    endgenerate

    // Both reads are combinational so the sequencer sees a table edit in the very cycle it issues.
    always_comb begin
        host_rdata_o = '0;
        seq_rdata_o  = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            if (host_raddr_i == 4'(i)) host_rdata_o = entry_w[i];
            if (seq_raddr_i == 4'(i))  seq_rdata_o  = entry_w[i];
        end
    end

endmodule

// File: rtl/dout_seq_ctrl.sv
// DOUT write-port sequencer: replays table entries with per-entry dwell, optionally looping,
// while host writes always take the port first and the sequencer fills idle cycles.
module dout_seq_ctrl
    import dout_seq_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [15:0] reg_raddr,
    input  logic [15:0] reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_wen,
    output logic [31:0] reg_rdata,
    output logic [15:0] dout_waddr,
    output logic [31:0] dout_wdata,
    output logic        dout_wen,
    output logic        seq_busy
);

    seq_state_t   state_q;
    logic [3:0]   idx_q;
    logic [15:0]  cnt_q;
    logic [3:0]   len_q;
    logic         loop_q;
    logic         done_q;
    logic         deferred_q;

    logic               wsel_d, rsel_d, ctrl_wr_d, tbl_we_d;
    logic               start_d, stop_d, loop_req_d;
    logic [3:0]         widx_d, ridx_d, len_req_d, len_d;
    logic               adv_d, last_d;
    logic [ENTRY_W-1:0] host_entry_d, seq_entry_d;
    logic [15:0]        seq_dwell_d;
    logic               unused_raddr;

    assign wsel_d     = (reg_waddr[15:12] == ADDR_DSEQ);
    assign widx_d     = reg_waddr[3:0];
    assign ctrl_wr_d  = reg_wen && wsel_d && (widx_d == OFF_DSEQ_CTRL);
    assign tbl_we_d   = reg_wen && wsel_d && (widx_d != OFF_DSEQ_CTRL);
    assign start_d    = reg_wdata[CTRL_START_BIT];
    assign stop_d     = reg_wdata[CTRL_STOP_BIT];
    assign loop_req_d = reg_wdata[CTRL_LOOP_BIT];
    assign len_req_d  = reg_wdata[CTRL_LEN_LSB +: CTRL_LEN_W];
    assign len_d      = (len_req_d > 4'(DEPTH)) ? 4'(DEPTH) : len_req_d;

    assign rsel_d       = (reg_raddr[15:12] == ADDR_DSEQ);
    assign ridx_d       = reg_raddr[3:0];
    assign unused_raddr = ^reg_raddr[11:4];

    dseq_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk          (sysclk),
        .rst_n_i      (reset),
        .we_i         (tbl_we_d),
        .waddr_i      (widx_d),
        .wdata_i      (pack_entry(reg_wdata)),
        .host_raddr_i (ridx_d),
        .host_rdata_o (host_entry_d),
        .seq_raddr_i  (idx_q + 4'd1),
        .seq_rdata_o  (seq_entry_d)
    );

    assign seq_dwell_d = seq_entry_d[27:12];
    assign last_d      = (idx_q == (len_q - 4'd1));
    // >= rather than == so a dwell shortened mid-count still terminates promptly.
    assign adv_d = ((state_q == ST_ISSUE) && !reg_wen && (seq_dwell_d == 16'd0)) ||
                   ((state_q == ST_DWELL) && (cnt_q >= seq_dwell_d));

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            done_q     <= 1'b0;
            deferred_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ISSUE: begin
                    if (reg_wen) begin
                        if (!(ctrl_wr_d && stop_d)) deferred_q <= 1'b1;
                    end else if (!adv_d) begin
                        cnt_q   <= 16'd1;
                        state_q <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (!adv_d) cnt_q <= cnt_q + 16'd1;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (adv_d) begin
                if (!last_d) begin
                    idx_q   <= idx_q + 4'd1;
                    state_q <= ST_ISSUE;
                end else if (loop_q) begin
                    idx_q   <= '0;
                    state_q <= ST_ISSUE;
                end else begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
            end

            // Control writes are applied last so they override the step above.
            if (ctrl_wr_d) begin
                if (stop_d) begin
                    state_q <= ST_IDLE;
                end else if (start_d) begin
                    if (len_d != 4'd0) begin
                        state_q    <= ST_ISSUE;
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        len_q      <= len_d;
                        loop_q     <= loop_req_d;
                        done_q     <= 1'b0;
                        deferred_q <= 1'b0;
                    end
                end else begin
                    loop_q <= loop_req_d;
                end
            end
        end
    end

    assign seq_busy = (state_q != ST_IDLE);

    always_comb begin
        reg_rdata = '0;
        if (rsel_d) begin
            if (ridx_d == OFF_DSEQ_CTRL) begin
                reg_rdata = {12'd0, idx_q, 4'd0, len_q, 3'd0,
                             deferred_q, done_q, loop_q, 1'b0, seq_busy};
            end else begin
                reg_rdata = unpack_entry(host_entry_d);
            end
        end
    end

    always_comb begin
        dout_waddr = '0;
        dout_wdata = '0;
        dout_wen   = 1'b0;
        if (reg_wen) begin
            dout_waddr = reg_waddr;
            dout_wdata = reg_wdata;
            dout_wen   = 1'b1;
        end else if (state_q == ST_ISSUE) begin
            dout_waddr = DOUT_SEQ_ADDR;
            dout_wdata = {20'd0, seq_entry_d[11:0]};
            dout_wen   = 1'b1;
        end
    end

endmodule

// File: tb/tb_dout_seq_ctrl.sv
// Scoreboard bench for dout_seq_ctrl: a timestamp-based playback model predicts every DOUT write,
// status/table reads and busy; a negedge monitor pops and compares.
module tb_dout_seq_ctrl;
    import dout_seq_ctrl_pkg::*;

    localparam int DEPTH = 8;
    localparam logic [15:0] SEQ_ADDR  = {ADDR_MAIN, 8'h00, REG_DIGIOUT};
    localparam logic [15:0] CTRL_ADDR = {ADDR_DSEQ, 12'h000};

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] reg_raddr = '0, reg_waddr = '0;
    logic [31:0] reg_wdata = '0;
    logic        reg_wen = 1'b0;
    logic [31:0] reg_rdata, dout_wdata;
    logic [15:0] dout_waddr;
    logic        dout_wen, seq_busy;

    always #5 sysclk = ~sysclk;

    dout_seq_ctrl #(.DEPTH(DEPTH)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .reg_raddr  (reg_raddr),
        .reg_waddr  (reg_waddr),
        .reg_wdata  (reg_wdata),
        .reg_wen    (reg_wen),
        .reg_rdata  (reg_rdata),
        .dout_waddr (dout_waddr),
        .dout_wdata (dout_wdata),
        .dout_wen   (dout_wen),
        .seq_busy   (seq_busy)
    );

    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         sbq[$];
    int          n_vec = 0, n_err = 0, cyc_n = 0;
    bit          mon_en = 1'b0;
    logic        exp_busy = 1'b0;
    logic [31:0] exp_rd = '0;
    logic [15:0] cur_ra = '0;

    // Reference model: playing flag, current entry, pending-issue flag and the cycle at which
    // the current entry's dwell expires.
    int         m_dwell[16];
    logic [3:0] m_mask[16], m_val[16];
    bit         m_play, m_wait, m_loop, m_done, m_def;
    int         m_pos, m_len, m_adv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_n, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [15:0] ra);
        int i = int'(ra[3:0]);
        if (ra[15:12] != ADDR_DSEQ) return 32'd0;
        if (i == 0)
            return {12'd0, 4'(m_pos), 4'd0, 4'(m_len), 3'd0, m_def, m_done, m_loop, 1'b0, m_play};
        if (i <= DEPTH) return {16'(m_dwell[i]), 4'd0, m_mask[i], 4'd0, m_val[i]};
        return 32'd0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_dwell[i] = 0; m_mask[i] = '0; m_val[i] = '0;
        end
        m_play = 0; m_wait = 0; m_loop = 0; m_done = 0; m_def = 0;
        m_pos = 0; m_len = 0; m_adv = -1;
    endtask

    task automatic model_cycle();
        bit pend, issue, ctl, def_prev;
        int e, lreq;
        exp_busy = m_play;
        exp_rd   = model_read(reg_raddr);
        pend  = m_play && m_wait;
        issue = 0;
        if (reg_wen) begin
            sbq.push_back('{cyc_n, reg_waddr, reg_wdata});
        end else if (pend) begin
            e = m_pos + 1;
            sbq.push_back('{cyc_n, SEQ_ADDR, {20'd0, m_mask[e], 4'd0, m_val[e]}});
            issue = 1;
        end
        if (!reset) begin
            model_clear();
            return;
        end
        def_prev = m_def;
        if (pend && reg_wen) m_def = 1;
        if (issue) begin
            m_wait = 0;
            m_adv  = cyc_n + m_dwell[m_pos + 1];
        end
        if (m_play && !m_wait && cyc_n == m_adv) begin
            if (m_pos < m_len - 1) begin m_pos++; m_wait = 1; end
            else if (m_loop) begin m_pos = 0; m_wait = 1; end
            else begin m_play = 0; m_done = 1; end
        end
        ctl = reg_wen && reg_waddr[15:12] == ADDR_DSEQ && reg_waddr[3:0] == 4'd0;
        if (ctl) begin
            if (reg_wdata[1]) begin
                m_play = 0;
                m_def  = def_prev;
            end else if (reg_wdata[0]) begin
                lreq = int'(reg_wdata[11:8]);
                if (lreq > DEPTH) lreq = DEPTH;
                if (lreq != 0) begin
                    m_play = 1; m_wait = 1; m_pos = 0; m_len = lreq;
                    m_loop = reg_wdata[2]; m_done = 0; m_def = 0;
                end
            end else begin
                m_loop = reg_wdata[2];
            end
        end
        if (reg_wen && reg_waddr[15:12] == ADDR_DSEQ && reg_waddr[3:0] != 4'd0 &&
            int'(reg_waddr[3:0]) <= DEPTH) begin
            e = int'(reg_waddr[3:0]);
            m_dwell[e] = int'(reg_wdata[31:16]);
            m_mask[e]  = reg_wdata[11:8];
            m_val[e]   = reg_wdata[3:0];
        end
    endtask

    task automatic drive(input logic rst, input logic wen, input logic [15:0] wa, input logic [31:0] wd);
        @(posedge sysclk);
        #1;
        cyc_n++;
        reset = rst; reg_wen = wen; reg_waddr = wa; reg_wdata = wd; reg_raddr = cur_ra;
        model_cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 16'h0000, 32'h0);
    endtask

    task automatic hw(input logic [15:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, a, d);
    endtask

    task automatic ctrl(input bit start, input bit stop, input bit loop, input logic [3:0] len);
        hw(CTRL_ADDR, {20'd0, len, 5'd0, loop, stop, start});
    endtask

    // Junk in bits 15:12 and 7:4 must not be stored.
    task automatic twr(input logic [3:0] i, input logic [15:0] dw, input logic [3:0] mask, input logic [3:0] val);
        hw({ADDR_DSEQ, 8'h00, i}, {dw, 4'hA, mask, 4'h5, val});
    endtask

    task automatic peek(input string nm, input logic [31:0] mask, input logic [31:0] exp);
        #2;
        chk(nm, reg_rdata & mask, exp);
    endtask

    task automatic wait_pos(input int target, input string nm);
        for (int k = 0; k < 60; k++) begin
            if (m_play && m_pos == target) return;
            idle(1);
        end
        n_vec++; n_err++;
        $display("FAIL %s timeout waiting for index %0d got none", nm, target);
    endtask

    always @(negedge sysclk) begin
        wr_t w;
        if (mon_en) begin
            chk("seq_busy", {31'd0, seq_busy}, {31'd0, exp_busy});
            chk("reg_rdata", reg_rdata, exp_rd);
            while (sbq.size() > 0 && sbq[0].cyc < cyc_n) begin
                w = sbq.pop_front();
                n_vec++; n_err++;
                $display("FAIL missed_write cyc=%0d got none want addr=%h data=%h", w.cyc, w.a, w.d);
            end
            if (dout_wen) begin
                if (sbq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_write cyc=%0d got addr=%h data=%h want none", cyc_n, dout_waddr, dout_wdata);
                end else begin
                    w = sbq.pop_front();
                    chk("wr_cycle", 32'(cyc_n), 32'(w.cyc));
                    chk("wr_addr", {16'd0, dout_waddr}, {16'd0, w.a});
                    chk("wr_data", dout_wdata, w.d);
                end
            end else begin
                chk("idle_addr", {16'd0, dout_waddr}, 32'd0);
                chk("idle_data", dout_wdata, 32'd0);
            end
        end
    end

    initial begin
        int r, e, dw;
        model_clear();
        cur_ra = CTRL_ADDR;
        drive(1'b0, 1'b0, 16'h0, 32'h0);
        drive(1'b0, 1'b0, 16'h0, 32'h0);
        mon_en = 1'b1;
        idle(2);
        peek("reset_status", 32'hFFFF_FFFF, 32'h0);

        // 1: single pass, 0x0F05 then 0x0100 four clocks later
        twr(4'd1, 16'd3, 4'hF, 4'h5);
        twr(4'd2, 16'd0, 4'h1, 4'h0);
        ctrl(1, 0, 0, 4'd2);
        idle(12);
        peek("t1_status", 32'hFFFF_FFFF, 32'h0001_0208);
        cur_ra = {ADDR_DSEQ, 12'h001};
        idle(1);
        peek("t1_entry1", 32'hFFFF_FFFF, 32'h0003_0F05);
        cur_ra = CTRL_ADDR;

        // 2: looping, then STOP in the middle of a dwell
        ctrl(1, 0, 1, 4'd2);
        idle(7);
        ctrl(0, 1, 0, 4'd0);
        idle(8);
        peek("t2_busy_done", 32'h0000_0009, 32'h0);

        // 3: host holds the port across the first issue cycle
        ctrl(1, 0, 0, 4'd2);
        hw(SEQ_ADDR, 32'h0000_0A0A);
        hw(16'h1004, 32'hDEAD_BEEF);
        hw(SEQ_ADDR, 32'h0000_0303);
        idle(10);
        peek("t3_deferred_done", 32'h0000_0018, 32'h0000_0018);

        // 4: zero length is ignored; oversize length clamps to DEPTH
        ctrl(1, 0, 0, 4'd0);
        idle(4);
        peek("t4_len0_busy", 32'h0000_0001, 32'h0);
        for (int i = 1; i <= DEPTH; i++)
            twr(4'(i), 16'(i % 2), 4'(i), ~4'(i));
        ctrl(1, 0, 0, 4'd12);
        idle(3);
        peek("t4_len_clamp", 32'h0000_0F00, 32'h0000_0800);
        idle(20);
        peek("t4_final_status", 32'hFFFF_FFFF, 32'h0007_0808);

        // 5: one-clock reset pulse in the middle of playback
        ctrl(1, 0, 1, 4'd2);
        idle(5);
        drive(1'b0, 1'b0, 16'h0, 32'h0);
        idle(1);
        peek("t5_status_zero", 32'hFFFF_FFFF, 32'h0);
        cur_ra = {ADDR_DSEQ, 12'h001};
        idle(1);
        peek("t5_table_zero", 32'hFFFF_FFFF, 32'h0);
        cur_ra = CTRL_ADDR;

        // 6: START+STOP together stops; START at index 2 restarts from entry 1
        twr(4'd1, 16'd2, 4'h1, 4'h1);
        twr(4'd2, 16'd2, 4'h2, 4'h2);
        twr(4'd3, 16'd2, 4'h4, 4'h3);
        ctrl(1, 0, 1, 4'd3);
        wait_pos(2, "t6_reach_idx2_a");
        ctrl(1, 1, 1, 4'd3);
        idle(3);
        peek("t6_startstop_busy", 32'h0000_0001, 32'h0);
        ctrl(1, 0, 1, 4'd3);
        wait_pos(2, "t6_reach_idx2_b");
        ctrl(1, 0, 1, 4'd3);
        idle(10);
        ctrl(0, 1, 0, 4'd0);
        idle(4);

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            r = $urandom_range(0, 99);
            cur_ra = {($urandom_range(0, 3) == 0) ? 4'h1 : ADDR_DSEQ, 8'($urandom), 4'($urandom_range(0, 15))};
            dw = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 25) : $urandom_range(0, 3);
            if (r < 6) begin
                e = $urandom_range(1, 15);
                if (m_play && e == m_pos + 1) e = (e % 15) + 1;
                hw({ADDR_DSEQ, 8'($urandom), 4'(e)}, {16'(dw), 16'($urandom)});
            end else if (r < 9) begin
                hw({ADDR_DSEQ, 8'($urandom), 4'h0},
                   {20'($urandom), 4'($urandom_range(0, 15)), 5'($urandom), 1'($urandom), 1'b0, 1'b1});
            end else if (r < 10) begin
                hw({ADDR_DSEQ, 8'($urandom), 4'h0}, {29'($urandom), 1'b1, 1'($urandom), 1'($urandom)} | 32'h2);
            end else if (r < 12) begin
                hw({ADDR_DSEQ, 8'($urandom), 4'h0}, {29'($urandom), 1'($urandom), 2'b00});
            end else if (r < 20) begin
                hw({4'($urandom_range(0, 12)), 12'($urandom)}, $urandom);
            end else begin
                idle(1);
            end
        end

        cur_ra = CTRL_ADDR;
        ctrl(0, 1, 0, 4'd0);
        idle(30);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
